// File: rtl/trace_pkg.sv
// Shared types for the commit trace front end: record layout, record kind
// and the capture state machine encoding.
package trace_pkg;

    localparam int TS_W = 64;

    typedef enum logic {
        INSTR = 1'b0,
        EXCP  = 1'b1
    } trace_kind_e;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } trace_state_e;

    typedef struct packed {
        trace_kind_e      kind;
        logic [1:0]       priv;
        logic [TS_W-1:0]  ts;
        logic [63:0]      pc;
        logic [31:0]      instr;
        logic [4:0]       rd;
        logic             we;
        logic             fpr;
        logic [63:0]      data;
        logic [63:0]      tval;
    } trace_rec_t;

endpackage

// File: rtl/trace_mwfifo.sv
// Circular record buffer accepting up to three writes and one read per cycle.
// The caller guarantees wr_n never exceeds the free space and rd_en is only
// raised while the buffer holds at least one record.
module trace_mwfifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             wr_n,
    input  trace_rec_t             wr_rec0,
    input  trace_rec_t             wr_rec1,
    input  trace_rec_t             wr_rec2,
    input  logic                   rd_en,
    output trace_rec_t             head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    trace_rec_t       mem [DEPTH];
    trace_rec_t       wr_arr [3];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign wr_arr[0] = wr_rec0;
    assign wr_arr[1] = wr_rec1;
    assign wr_arr[2] = wr_rec2;

    // Storage: the first wr_n compacted records land in consecutive slots.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (i < int'(wr_n)) begin
                mem[wr_ptr + AW'(i)] <= wr_arr[i];
            end
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_n);
            rd_ptr <= rd_ptr + AW'(rd_en);
            count  <= count + CW'(wr_n) - CW'(rd_en);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/commit_trace_arbiter.sv
// Commit trace front end: stamps up to two commits and one exception per
// cycle with a free-running cycle count, compacts them in program order and
// queues them for a valid/ready sink. A cycle whose records do not all fit is
// dropped as a whole and counted, so the core is never stalled.
module commit_trace_arbiter
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              trace_en_i,
    input  logic [1:0]        commit_valid_i,
    input  logic [127:0]      commit_pc_i,
    input  logic [63:0]       commit_instr_i,
    input  logic [9:0]        commit_rd_i,
    input  logic [1:0]        commit_we_i,
    input  logic [1:0]        commit_fpr_i,
    input  logic [127:0]      commit_wdata_i,
    input  logic [1:0]        priv_lvl_i,
    input  logic              ex_valid_i,
    input  logic [63:0]       ex_pc_i,
    input  logic [63:0]       ex_cause_i,
    input  logic [63:0]       ex_tval_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output trace_rec_t        out_rec_o,
    output logic [CNT_W-1:0]  drop_cnt_o,
    output logic              overflow_o,
    output logic              drained_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = CW + 1;
    localparam int DW = CNT_W + 1;

    trace_state_e     state;
    trace_state_e     state_nxt;
    logic [TS_W-1:0]  ts;
    logic [CW-1:0]    count;
    logic             empty;
    trace_rec_t       head;
    logic             pop;
    logic             capture;
    logic [1:0]       n;
    logic [FW-1:0]    free;
    logic             admit;
    logic             drop;
    logic [1:0]       wr_n;
    logic [DW-1:0]    drop_sum;
    logic             drain_done;
    trace_rec_t       cand0;
    trace_rec_t       cand1;
    trace_rec_t       cand_ex;
    trace_rec_t       slot0;
    trace_rec_t       slot1;
    trace_rec_t       slot2;

    // Free-running cycle stamp; zero in the first cycle after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
        end
    end

    // Build the three candidate records from the commit-stage inputs.
    always_comb begin
        cand0       = '0;
        cand0.kind  = INSTR;
        cand0.priv  = priv_lvl_i;
        cand0.ts    = ts;
        cand0.pc    = commit_pc_i[63:0];
        cand0.instr = commit_instr_i[31:0];
        cand0.rd    = commit_rd_i[4:0];
        cand0.we    = commit_we_i[0];
        cand0.fpr   = commit_fpr_i[0];
        cand0.data  = commit_wdata_i[63:0];

        cand1       = '0;
        cand1.kind  = INSTR;
        cand1.priv  = priv_lvl_i;
        cand1.ts    = ts;
        cand1.pc    = commit_pc_i[127:64];
        cand1.instr = commit_instr_i[63:32];
        cand1.rd    = commit_rd_i[9:5];
        cand1.we    = commit_we_i[1];
        cand1.fpr   = commit_fpr_i[1];
        cand1.data  = commit_wdata_i[127:64];

        cand_ex      = '0;
        cand_ex.kind = EXCP;
        cand_ex.priv = priv_lvl_i;
        cand_ex.ts   = ts;
        cand_ex.pc   = ex_pc_i;
        cand_ex.data = ex_cause_i;
        cand_ex.tval = ex_tval_i;
    end

    // Compact valid candidates into write slots in program order.
    always_comb begin
        slot0 = cand_ex;
        slot1 = cand_ex;
        slot2 = cand_ex;
        case (commit_valid_i)
            2'b11: begin
                slot0 = cand0;
                slot1 = cand1;
            end
            2'b01: slot0 = cand0;
            2'b10: slot0 = cand1;
            default: ;
        endcase
    end

    assign n = 2'({1'b0, commit_valid_i[0]} + {1'b0, commit_valid_i[1]} + {1'b0, ex_valid_i});

    assign out_valid_o = !empty;
    assign out_rec_o   = empty ? '0 : head;
    assign pop         = out_valid_o & out_ready_i;

    // Admission is all-or-nothing; a same-cycle pop frees one extra slot.
    assign capture = (state == RUN);
    assign free    = FW'(DEPTH) - FW'(count) + FW'(pop);
    assign admit   = capture && (FW'(n) <= free);
    assign drop    = capture && !admit;
    assign wr_n    = admit ? n : 2'd0;

    assign drop_sum = {1'b0, drop_cnt_o} + DW'(n);

    // Saturating drop counter and sticky overflow flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_o <= '0;
            overflow_o <= 1'b0;
        end else if (drop) begin
            drop_cnt_o <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            overflow_o <= 1'b1;
        end
    end

    // Capture state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= OFF;
        end else begin
            state <= state_nxt;
        end
    end

    // DRAIN finishes as soon as the buffer is empty after this cycle's pop,
    // so drained_o rises in the cycle right after the last record leaves.
    assign drain_done = empty || ((count == CW'(1)) && pop);

    // Next-state logic; re-enabling while draining resumes capture at once.
    always_comb begin
        state_nxt = state;
        case (state)
            OFF:     if (trace_en_i) state_nxt = RUN;
            RUN:     if (!trace_en_i) state_nxt = DRAIN;
            DRAIN: begin
                if (trace_en_i) begin
                    state_nxt = RUN;
                end else if (drain_done) begin
                    state_nxt = OFF;
                end
            end
            default: state_nxt = OFF;
        endcase
    end

    assign drained_o = (state == OFF) && empty;

    trace_mwfifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .wr_n    (wr_n),
        .wr_rec0 (slot0),
        .wr_rec1 (slot1),
        .wr_rec2 (slot2),
        .rd_en   (pop),
        .head    (head),
        .count   (count),
        .empty   (empty)
    );

endmodule

// File: tb/tb_commit_trace_arbiter.sv
// Bench for commit_trace_arbiter: directed scenarios followed by randomized
// traffic, all compared cycle by cycle against a queue-based reference model.
module tb_commit_trace_arbiter;
    import trace_pkg::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;
    localparam int RW    = $bits(trace_rec_t);
    localparam int M_OFF = 0;
    localparam int M_RUN = 1;
    localparam int M_DRAIN = 2;
    localparam longint unsigned DROP_MAX = (64'd1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              trace_en_i;
    logic [1:0]        commit_valid_i;
    logic [127:0]      commit_pc_i;
    logic [63:0]       commit_instr_i;
    logic [9:0]        commit_rd_i;
    logic [1:0]        commit_we_i;
    logic [1:0]        commit_fpr_i;
    logic [127:0]      commit_wdata_i;
    logic [1:0]        priv_lvl_i;
    logic              ex_valid_i;
    logic [63:0]       ex_pc_i;
    logic [63:0]       ex_cause_i;
    logic [63:0]       ex_tval_i;
    logic              out_valid_o;
    logic              out_ready_i;
    trace_rec_t        out_rec_o;
    logic [CNT_W-1:0]  drop_cnt_o;
    logic              overflow_o;
    logic              drained_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    trace_rec_t        mq[$];
    int                mstate;
    longint unsigned   mts;
    longint unsigned   mdrop;
    bit                movf;

    commit_trace_arbiter #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .trace_en_i     (trace_en_i),
        .commit_valid_i (commit_valid_i),
        .commit_pc_i    (commit_pc_i),
        .commit_instr_i (commit_instr_i),
        .commit_rd_i    (commit_rd_i),
        .commit_we_i    (commit_we_i),
        .commit_fpr_i   (commit_fpr_i),
        .commit_wdata_i (commit_wdata_i),
        .priv_lvl_i     (priv_lvl_i),
        .ex_valid_i     (ex_valid_i),
        .ex_pc_i        (ex_pc_i),
        .ex_cause_i     (ex_cause_i),
        .ex_tval_i      (ex_tval_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_rec_o      (out_rec_o),
        .drop_cnt_o     (drop_cnt_o),
        .overflow_o     (overflow_o),
        .drained_o      (drained_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic trace_rec_t mk_instr(input int p, input longint unsigned t);
        trace_rec_t r;
        r       = '0;
        r.kind  = INSTR;
        r.priv  = priv_lvl_i;
        r.ts    = t;
        r.pc    = commit_pc_i[p*64 +: 64];
        r.instr = commit_instr_i[p*32 +: 32];
        r.rd    = commit_rd_i[p*5 +: 5];
        r.we    = commit_we_i[p];
        r.fpr   = commit_fpr_i[p];
        r.data  = commit_wdata_i[p*64 +: 64];
        return r;
    endfunction

    function automatic trace_rec_t mk_excp(input longint unsigned t);
        trace_rec_t r;
        r      = '0;
        r.kind = EXCP;
        r.priv = priv_lvl_i;
        r.ts   = t;
        r.pc   = ex_pc_i;
        r.data = ex_cause_i;
        r.tval = ex_tval_i;
        return r;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_update();
        trace_rec_t cand[$];
        int free;
        bit pop;
        if (rst_i) begin
            mq.delete();
            mstate = M_OFF;
            mts    = 0;
            mdrop  = 0;
            movf   = 0;
            return;
        end
        if (commit_valid_i[0]) cand.push_back(mk_instr(0, mts));
        if (commit_valid_i[1]) cand.push_back(mk_instr(1, mts));
        if (ex_valid_i)        cand.push_back(mk_excp(mts));
        pop  = (mq.size() > 0) && out_ready_i;
        free = DEPTH - mq.size() + (pop ? 1 : 0);
        if (pop) void'(mq.pop_front());
        if (mstate == M_RUN) begin
            if (cand.size() <= free) begin
                foreach (cand[i]) mq.push_back(cand[i]);
            end else begin
                mdrop = mdrop + cand.size();
                if (mdrop > DROP_MAX) mdrop = DROP_MAX;
                movf = 1;
            end
        end
        case (mstate)
            M_OFF:   if (trace_en_i) mstate = M_RUN;
            M_RUN:   if (!trace_en_i) mstate = M_DRAIN;
            default: begin
                if (trace_en_i) mstate = M_RUN;
                else if (mq.size() == 0) mstate = M_OFF;
            end
        endcase
        mts++;
    endtask

    task automatic compare_all();
        trace_rec_t exp_rec;
        exp_rec = (mq.size() > 0) ? mq[0] : '0;
        check_eq("out_valid", RW'(out_valid_o), RW'(mq.size() > 0));
        check_eq("out_rec", out_rec_o, exp_rec);
        check_eq("drop_cnt", RW'(drop_cnt_o), RW'(mdrop));
        check_eq("overflow", RW'(overflow_o), RW'(movf));
        check_eq("drained", RW'(drained_o), RW'((mstate == M_OFF) && (mq.size() == 0)));
    endtask

    // One clock: model sees the driven inputs, DUT samples them, compare after.
    task automatic step();
        model_update();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic rand_fields();
        commit_pc_i    = {$urandom, $urandom, $urandom, $urandom};
        commit_instr_i = {$urandom, $urandom};
        commit_rd_i    = 10'($urandom);
        commit_we_i    = 2'($urandom);
        commit_fpr_i   = 2'($urandom);
        commit_wdata_i = {$urandom, $urandom, $urandom, $urandom};
        priv_lvl_i     = 2'($urandom);
        ex_pc_i        = {$urandom, $urandom};
        ex_cause_i     = {$urandom, $urandom};
        ex_tval_i      = {$urandom, $urandom};
    endtask

    task automatic offer(input logic [1:0] v, input logic ex);
        rand_fields();
        commit_valid_i = v;
        ex_valid_i     = ex;
    endtask

    initial begin
        rst_i = 1'b1;
        trace_en_i = 1'b0;
        out_ready_i = 1'b0;
        offer(2'b00, 1'b0);
        @(negedge clk);
        step();
        step();
        rst_i = 1'b0;

        // Three records in one cycle, program order, shared stamp.
        trace_en_i = 1'b1;
        step();
        step();
        offer(2'b11, 1'b1);
        commit_pc_i[63:0]   = 64'h1000;
        commit_pc_i[127:64] = 64'h1004;
        ex_cause_i = 64'd2;
        step();
        check_eq("t1_pc0", RW'(out_rec_o.pc), RW'(64'h1000));
        check_eq("t1_ts0", RW'(out_rec_o.ts), RW'(64'd2));
        offer(2'b00, 1'b0);
        out_ready_i = 1'b1;
        step();
        check_eq("t1_pc1", RW'(out_rec_o.pc), RW'(64'h1004));
        step();
        check_eq("t1_kind2", RW'(out_rec_o.kind), RW'(EXCP));
        check_eq("t1_cause2", RW'(out_rec_o.data), RW'(64'd2));
        check_eq("t1_ts2", RW'(out_rec_o.ts), RW'(64'd2));
        step();

        // Lone port-1 commit compacts into slot 0.
        out_ready_i = 1'b0;
        offer(2'b10, 1'b0);
        commit_pc_i[127:64] = 64'h2000;
        step();
        check_eq("t2_pc", RW'(out_rec_o.pc), RW'(64'h2000));
        check_eq("t2_kind", RW'(out_rec_o.kind), RW'(INSTR));
        offer(2'b00, 1'b0);
        out_ready_i = 1'b1;
        step();
        check_eq("t2_single", RW'(out_valid_o), RW'(1'b0));

        // Fill to 15, overflow with 2, then 1 fits.
        out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            offer(2'b11, 1'b1);
            step();
        end
        offer(2'b11, 1'b0);
        step();
        check_eq("t3_drop", RW'(drop_cnt_o), RW'(16'd2));
        check_eq("t3_ovf", RW'(overflow_o), RW'(1'b1));
        offer(2'b01, 1'b0);
        step();
        check_eq("t3_fit", RW'(drop_cnt_o), RW'(16'd2));

        // Full buffer with a pop admits one record in the same cycle.
        out_ready_i = 1'b1;
        offer(2'b01, 1'b0);
        step();
        check_eq("t4_nodrop", RW'(drop_cnt_o), RW'(16'd2));
        out_ready_i = 1'b0;
        offer(2'b01, 1'b0);
        step();
        check_eq("t4_still_full", RW'(drop_cnt_o), RW'(16'd3));

        // Empty, buffer 5, then disable and drain.
        out_ready_i = 1'b1;
        offer(2'b00, 1'b0);
        for (int i = 0; i < DEPTH; i++) step();
        check_eq("t5_empty", RW'(out_valid_o), RW'(1'b0));
        out_ready_i = 1'b0;
        offer(2'b11, 1'b1);
        step();
        offer(2'b11, 1'b0);
        step();
        trace_en_i = 1'b0;
        offer(2'b00, 1'b0);
        step();
        out_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            offer(2'b11, 1'b1);
            step();
            check_eq("t5_drained", RW'(drained_o), RW'(i == 4));
        end
        check_eq("t5_ignored", RW'(drop_cnt_o), RW'(16'd3));

        // Reset with 8 records buffered.
        trace_en_i = 1'b1;
        out_ready_i = 1'b0;
        offer(2'b00, 1'b0);
        step();
        offer(2'b11, 1'b1);
        step();
        offer(2'b11, 1'b1);
        step();
        offer(2'b11, 1'b0);
        step();
        rst_i = 1'b1;
        step();
        check_eq("t6_valid", RW'(out_valid_o), RW'(1'b0));
        check_eq("t6_drop", RW'(drop_cnt_o), RW'(16'd0));
        check_eq("t6_drained", RW'(drained_o), RW'(1'b1));
        rst_i = 1'b0;
        offer(2'b00, 1'b0);
        step();
        offer(2'b01, 1'b0);
        step();
        check_eq("t6_ts", RW'(out_rec_o.ts), RW'(64'd1));

        // Randomized traffic in blocks with varying enable and sink pressure.
        for (int b = 0; b < 60; b++) begin
            int rdy_pct;
            trace_en_i = ($urandom_range(0, 3) != 0);
            rdy_pct    = $urandom_range(10, 100);
            for (int c = 0; c < 40; c++) begin
                rst_i = ($urandom_range(0, 399) == 0);
                if ($urandom_range(0, 19) == 0) trace_en_i = ~trace_en_i;
                out_ready_i = ($urandom_range(1, 100) <= rdy_pct);
                offer(2'($urandom), 1'($urandom_range(0, 3) == 0));
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
